// File: rtl/line_seq_pkg.sv
// line_seq_pkg
// Shared types and constants for the line sequencer and its line FIFO.
//   LINE_W      : width of one 5x5 grid line
//   DEPTH_DEF   : default line buffer depth (power of two)
//   JOB_W_DEF   : default job counter width
//   seq_state_t : sequencer FSM state encoding
//   line_t      : one buffered grid line
package line_seq_pkg;

    localparam int LINE_W    = 25;
    localparam int DEPTH_DEF = 32;
    localparam int JOB_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } seq_state_t;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/line_fifo.sv
// line_fifo
// Synchronous, order-preserving line buffer with registered pop data.
// Full and empty come from the occupancy count, so the pointers can wrap
// naturally at DEPTH.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wr_data : write strobe and line (dropped when full)
//   pop           : read strobe (ignored when empty)
//   rd_data       : last popped line, held until the next pop
//   level         : number of buffered lines
//   full, empty   : decoded from level
module line_fifo
    import line_seq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  line_t         wr_data,
    input  logic          pop,
    output line_t         rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    line_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // Both qualifiers use the cycle-start level: a pop never frees a slot
    // for a write in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/line_sequencer.sv
// line_sequencer
// Feeds buffered grid lines to the line-processing Controller: launches it
// with a one-cycle start, answers each readLine with the next line, counts
// completed jobs and relaunches while lines remain.
// Optional feature macro: LINE_SEQ_UNDERFLOW_EN (adds sticky `underflow`;
// a readLine on an empty buffer then aborts the batch to IDLE).
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   wr_en, wr_data, wr_ready: loader write interface
//   go                      : begin batch (IDLE only, needs level > 0)
//   start                   : one-cycle Controller launch pulse
//   readLine, line, line_valid : line request / delivered line
//   done                    : Controller finished current job
//   busy, batch_done, jobs  : status
//   level                   : buffered line count
//   underflow               : (macro only) sticky empty-read flag
//
// state | meaning
// IDLE  | waiting for go with a non-empty buffer
// START | start pulse high for this cycle
// RUN   | serving readLine, waiting for done
// FIN   | batch_done pulse high for this cycle
module line_sequencer
    import line_seq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int JOB_W = JOB_W_DEF,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  line_t            wr_data,
    output logic             wr_ready,
    input  logic             go,
    output logic             start,
    input  logic             readLine,
    output line_t            line,
    output logic             line_valid,
    input  logic             done,
    output logic             busy,
    output logic             batch_done,
    output logic [JOB_W-1:0] jobs,
    output logic [LVL_W-1:0] level
`ifdef LINE_SEQ_UNDERFLOW_EN
    ,
    output logic             underflow
`endif
);

    seq_state_t       state;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;
    logic [LVL_W-1:0] level_nxt;

    assign wr_ready  = !full;
    assign busy      = (state != IDLE);
    assign push_ok   = wr_en && !full;
    assign pop_ok    = (state == RUN) && readLine && !empty;
    // Occupancy after this cycle's push/pop decides relaunch versus finish.
    assign level_nxt = level + LVL_W'(push_ok) - LVL_W'(pop_ok);

    line_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_ok),
        .wr_data (wr_data),
        .pop     (pop_ok),
        .rd_data (line),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            start      <= 1'b0;
            batch_done <= 1'b0;
            line_valid <= 1'b0;
            jobs       <= '0;
`ifdef LINE_SEQ_UNDERFLOW_EN
            underflow  <= 1'b0;
`endif
        end else begin
            start      <= 1'b0;
            batch_done <= 1'b0;
            line_valid <= pop_ok;
            case (state)
                IDLE: begin
                    if (go && !empty) begin
                        jobs  <= '0;
                        start <= 1'b1;
                        state <= START;
`ifdef LINE_SEQ_UNDERFLOW_EN
                        underflow <= 1'b0;
`endif
                    end
                end
                START: state <= RUN;
                RUN: begin
`ifdef LINE_SEQ_UNDERFLOW_EN
                    if (readLine && empty) begin
                        underflow <= 1'b1;
                        state     <= IDLE;
                    end else if (done) begin
`else
                    if (done) begin
`endif
                        if (jobs != '1) begin
                            jobs <= jobs + JOB_W'(1);
                        end
                        if (level_nxt != '0) begin
                            start <= 1'b1;
                            state <= START;
                        end else begin
                            batch_done <= 1'b1;
                            state      <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer
// Directed bench for line_sequencer: a vector table for the basic batch,
// relaunch and same-cycle readLine/done cases, then hand-written sequences
// for the full boundary, empty read and reset mid-batch.
module tb_line_sequencer;
    import line_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    line_t      wr_data;
    logic       wr_ready;
    logic       go;
    logic       start;
    logic       readLine;
    line_t      line;
    logic       line_valid;
    logic       done;
    logic       busy;
    logic       batch_done;
    logic [7:0] jobs;
    logic [5:0] level;
`ifdef LINE_SEQ_UNDERFLOW_EN
    logic       underflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .go         (go),
        .start      (start),
        .readLine   (readLine),
        .line       (line),
        .line_valid (line_valid),
        .done       (done),
        .busy       (busy),
        .batch_done (batch_done),
        .jobs       (jobs),
        .level      (level)
`ifdef LINE_SEQ_UNDERFLOW_EN
        ,
        .underflow  (underflow)
`endif
    );

    typedef struct {
        logic       we;
        line_t      wd;
        logic       go;
        logic       rl;
        logic       dn;
        logic       st;
        logic       lv;
        line_t      ln;
        logic       bsy;
        logic       bd;
        logic [7:0] jb;
        logic [5:0] lvl;
    } vec_t;

    vec_t tbl [23];

    localparam line_t A1 = 25'h0ABCDEF;
    localparam line_t A2 = 25'h1234567;
    localparam line_t A3 = 25'h0F0F0F0;
    localparam line_t A4 = 25'h1000000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at a negedge, return at the next negedge.
    task automatic cyc(input logic we, input line_t wd, input logic g,
                       input logic rl, input logic dn);
        wr_en = we; wr_data = wd; go = g; readLine = rl; done = dn;
        @(negedge clk);
        wr_en = 1'b0; go = 1'b0; readLine = 1'b0; done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, '0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; go = 1'b0; readLine = 1'b0; done = 1'b0;

        //            we wd          go rl dn  st lv ln          bsy bd jb lvl
        tbl[0]  = '{1, 25'h1FFFFFF, 0, 0, 0,  0, 0, 25'h0,       0, 0, 0, 1};
        tbl[1]  = '{1, 25'h0000001, 0, 0, 0,  0, 0, 25'h0,       0, 0, 0, 2};
        tbl[2]  = '{1, 25'h1555555, 0, 0, 0,  0, 0, 25'h0,       0, 0, 0, 3};
        tbl[3]  = '{0, 25'h0,       1, 0, 0,  1, 0, 25'h0,       1, 0, 0, 3};
        tbl[4]  = '{0, 25'h0,       0, 0, 0,  0, 0, 25'h0,       1, 0, 0, 3};
        tbl[5]  = '{0, 25'h0,       0, 1, 0,  0, 1, 25'h1FFFFFF, 1, 0, 0, 2};
        tbl[6]  = '{0, 25'h0,       0, 1, 0,  0, 1, 25'h0000001, 1, 0, 0, 1};
        tbl[7]  = '{0, 25'h0,       0, 1, 0,  0, 1, 25'h1555555, 1, 0, 0, 0};
        tbl[8]  = '{0, 25'h0,       0, 0, 1,  0, 0, 25'h1555555, 1, 1, 1, 0};
        tbl[9]  = '{0, 25'h0,       0, 0, 0,  0, 0, 25'h1555555, 0, 0, 1, 0};
        tbl[10] = '{1, A1,          0, 0, 0,  0, 0, 25'h1555555, 0, 0, 1, 1};
        tbl[11] = '{1, A2,          0, 0, 0,  0, 0, 25'h1555555, 0, 0, 1, 2};
        tbl[12] = '{1, A3,          0, 0, 0,  0, 0, 25'h1555555, 0, 0, 1, 3};
        tbl[13] = '{1, A4,          0, 0, 0,  0, 0, 25'h1555555, 0, 0, 1, 4};
        tbl[14] = '{0, 25'h0,       1, 0, 0,  1, 0, 25'h1555555, 1, 0, 0, 4};
        tbl[15] = '{0, 25'h0,       0, 0, 0,  0, 0, 25'h1555555, 1, 0, 0, 4};
        tbl[16] = '{0, 25'h0,       0, 1, 0,  0, 1, A1,          1, 0, 0, 3};
        tbl[17] = '{0, 25'h0,       0, 1, 0,  0, 1, A2,          1, 0, 0, 2};
        tbl[18] = '{0, 25'h0,       0, 0, 1,  1, 0, A2,          1, 0, 1, 2};
        tbl[19] = '{0, 25'h0,       0, 0, 0,  0, 0, A2,          1, 0, 1, 2};
        tbl[20] = '{0, 25'h0,       1, 1, 0,  0, 1, A3,          1, 0, 1, 1};
        tbl[21] = '{0, 25'h0,       0, 1, 1,  0, 1, A4,          1, 1, 2, 0};
        tbl[22] = '{0, 25'h0,       0, 0, 0,  0, 0, A4,          0, 0, 2, 0};

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_level", level, 0);
        chk("rst_line", line, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_start", start, 0);
        chk("rst_batch_done", batch_done, 0);
        chk("rst_jobs", jobs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
`ifdef LINE_SEQ_UNDERFLOW_EN
        chk("rst_underflow", underflow, 0);
`endif

        // Basic batch, relaunch, same-cycle readLine+done, go ignored in RUN
        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].we, tbl[i].wd, tbl[i].go, tbl[i].rl, tbl[i].dn);
            chk($sformatf("v%0d_start", i), start, tbl[i].st);
            chk($sformatf("v%0d_line_valid", i), line_valid, tbl[i].lv);
            chk($sformatf("v%0d_line", i), line, tbl[i].ln);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("v%0d_batch_done", i), batch_done, tbl[i].bd);
            chk($sformatf("v%0d_jobs", i), jobs, tbl[i].jb);
            chk($sformatf("v%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("v%0d_wr_ready", i), wr_ready, (tbl[i].lvl != 6'd32));
        end

        // Full boundary: 32 writes fill, 33rd dropped, push+pop at full
        do_reset();
        for (int i = 0; i < 32; i++) begin
            chk("fill_wr_ready", wr_ready, 1);
            cyc(1, line_t'(32'h100 + i), 0, 0, 0);
        end
        chk("full_level", level, 32);
        chk("full_wr_ready", wr_ready, 0);
        cyc(1, 25'h1ABCDEF, 0, 0, 0);
        chk("drop33_level", level, 32);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(1, 25'h1EEEEEE, 0, 1, 0);
        chk("pushpop_line", line, 25'h100);
        chk("pushpop_valid", line_valid, 1);
        chk("pushpop_level", level, 31);
        chk("pushpop_wr_ready", wr_ready, 1);
        for (int i = 1; i < 32; i++) begin
            cyc(0, '0, 0, 1, 0);
            chk("drain_line", line, 32'h100 + i);
        end
        chk("drain_level", level, 0);
        cyc(0, '0, 0, 0, 1);
        chk("drain_batch_done", batch_done, 1);
        cyc(0, '0, 0, 0, 0);

        // Empty read in RUN
        do_reset();
        cyc(1, 25'h0123456, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        chk("er_first_line", line, 25'h0123456);
        chk("er_first_level", level, 0);
        cyc(0, '0, 0, 1, 0);
        chk("er_line_valid", line_valid, 0);
        chk("er_line", line, 25'h0123456);
        chk("er_batch_done", batch_done, 0);
`ifdef LINE_SEQ_UNDERFLOW_EN
        chk("er_underflow", underflow, 1);
        chk("er_busy", busy, 0);
        cyc(0, '0, 0, 0, 0);
        chk("er_batch_done2", batch_done, 0);
        chk("er_underflow_sticky", underflow, 1);
        cyc(1, 25'h0000777, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        chk("er_go_clears_underflow", underflow, 0);
        chk("er_go_start", start, 1);
`else
        chk("er_busy", busy, 1);
        cyc(0, '0, 0, 0, 0);
        chk("er_busy2", busy, 1);
        chk("er_batch_done2", batch_done, 0);
        cyc(0, '0, 0, 0, 1);
        chk("er_fin_batch_done", batch_done, 1);
        cyc(0, '0, 0, 0, 0);
        chk("er_idle_busy", busy, 0);
`endif

        // Reset mid-batch
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, line_t'(32'h20 + i), 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        chk("rm_relaunch_start", start, 1);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        chk("rm_pre_line", line, 25'h20);
        chk("rm_pre_level", level, 5);
        chk("rm_pre_jobs", jobs, 1);
        rst = 1'b1;
        cyc(0, '0, 0, 0, 0);
        rst = 1'b0;
        chk("rm_level", level, 0);
        chk("rm_line", line, 0);
        chk("rm_line_valid", line_valid, 0);
        chk("rm_start", start, 0);
        chk("rm_batch_done", batch_done, 0);
        chk("rm_jobs", jobs, 0);
        chk("rm_busy", busy, 0);
        chk("rm_wr_ready", wr_ready, 1);
        cyc(0, '0, 1, 0, 0);
        chk("rm_go_start", start, 0);
        chk("rm_go_busy", busy, 0);
        cyc(0, '0, 0, 0, 0);
        chk("rm_go_busy2", busy, 0);
        chk("rm_go_batch_done", batch_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
